// File: rtl/rgb_pwm_fader_pkg.sv
// Shared types and default parameters for the RGB PWM fader.
package rgb_pwm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FADE_OUT,
    LOAD,
    FADE_IN
  } fade_state_e;

  typedef logic [2:0] color_t;

  localparam int DEF_PWM_BITS   = 8;
  localparam int DEF_PWM_DIV    = 16;
  localparam int DEF_FADE_TICKS = 4;

endpackage

// File: rtl/rgb_pwm_fader_if.sv
// Colour-code handshake between the upstream sequencer and the fader.
interface rgb_pwm_fader_if;
  import rgb_pwm_pkg::*;

  logic   color_valid;
  color_t color;
  logic   color_ready;

  modport master (output color_valid, output color, input color_ready);
  modport slave  (input color_valid, input color, output color_ready);
endinterface

// File: rtl/rgb_pwm_fader_timebase.sv
// Free-running PWM timebase: prescaler followed by the PWM step counter.
// period_tick is high during the cycle whose closing edge wraps pwm_cnt.
module pwm_timebase #(
  parameter int PWM_BITS = 8,
  parameter int PWM_DIV  = 16
) (
  input  logic                clk,
  input  logic                rst,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                period_tick
);

  localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PWM_DIV - 1);

  logic [PRE_W-1:0] prescaler;
  logic             pre_wrap;

  assign pre_wrap    = (prescaler == PRE_LAST);
  assign period_tick = pre_wrap && (pwm_cnt == '1);

  // Prescaler counts 0..PWM_DIV-1; pwm_cnt advances on each prescaler wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
      pwm_cnt   <= '0;
    end else begin
      prescaler <= pre_wrap ? '0 : prescaler + 1'b1;
      if (pre_wrap) pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rgb_pwm_fader.sv
// rgb_pwm_fader: accepts a 3-bit colour code and cross-fades the two LEDs to
// it (fade out, swap colour, fade in). LED 0 shows the colour, LED 1 its
// complement, both at the same PWM brightness.
// Build option RGB_PWM_GAMMA_EN: quadratic duty curve; undefined -> linear.
module rgb_pwm_fader
  import rgb_pwm_pkg::*;
#(
  parameter int PWM_BITS   = DEF_PWM_BITS,
  parameter int PWM_DIV    = DEF_PWM_DIV,
  parameter int FADE_TICKS = DEF_FADE_TICKS
) (
  input  logic           clk,
  input  logic           rst,
  rgb_pwm_fader_if.slave color_if,
  output color_t         rgb_3bits_0,
  output color_t         rgb_3bits_1,
  output logic           busy
);

  localparam int FC_W = (FADE_TICKS > 1) ? $clog2(FADE_TICKS) : 1;
  localparam logic [FC_W-1:0]     FC_LAST   = FC_W'(FADE_TICKS - 1);
  localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;
  localparam logic [PWM_BITS-1:0] LEVEL_ONE = PWM_BITS'(1);

  fade_state_e         state, state_nxt;
  logic [PWM_BITS-1:0] level, level_nxt;
  color_t              cur_color, cur_color_nxt;
  color_t              pending, pending_nxt;
  logic [FC_W-1:0]     fade_cnt, fade_cnt_nxt;

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty;
  logic                period_tick;
  logic                fading;
  logic                fade_step;
  logic                xfer;
  logic                pwm_on;

  pwm_timebase #(
    .PWM_BITS (PWM_BITS),
    .PWM_DIV  (PWM_DIV)
  ) u_timebase (
    .clk         (clk),
    .rst         (rst),
    .pwm_cnt     (pwm_cnt),
    .period_tick (period_tick)
  );

  assign color_if.color_ready = (state == IDLE);
  assign busy      = !color_if.color_ready;
  assign xfer      = color_if.color_valid && color_if.color_ready;
  assign fading    = (state == FADE_OUT) || (state == FADE_IN);
  assign fade_step = fading && period_tick && (fade_cnt == FC_LAST);

`ifdef RGB_PWM_GAMMA_EN
  // (level+1)^2 - 1 keeps both endpoints exact: 0 -> 0 and max -> max.
  logic [2*PWM_BITS-1:0] lvl_p1;
  logic [2*PWM_BITS-1:0] lvl_sq;
  assign lvl_p1 = (2*PWM_BITS)'(level) + 1'b1;
  assign lvl_sq = lvl_p1 * lvl_p1 - 1'b1;
  assign duty   = PWM_BITS'(lvl_sq >> PWM_BITS);
`else
  assign duty = level;
`endif

  assign pwm_on = (duty != '0) && (pwm_cnt <= duty);

  // State, brightness and colour registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      level     <= '0;
      cur_color <= '0;
      pending   <= '0;
      fade_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      level     <= level_nxt;
      cur_color <= cur_color_nxt;
      pending   <= pending_nxt;
      fade_cnt  <= fade_cnt_nxt;
    end
  end

  // Next-state logic; level steps are blocked at 0 and at max.
  always_comb begin
    state_nxt     = state;
    level_nxt     = level;
    cur_color_nxt = cur_color;
    pending_nxt   = pending;
    fade_cnt_nxt  = fade_cnt;

    if (fading && period_tick)
      fade_cnt_nxt = (fade_cnt == FC_LAST) ? '0 : fade_cnt + 1'b1;

    case (state)
      IDLE: begin
        if (xfer) begin
          pending_nxt  = color_if.color;
          fade_cnt_nxt = '0;
          state_nxt    = FADE_OUT;
        end
      end
      FADE_OUT: begin
        if (level == '0) begin
          state_nxt = LOAD;
        end else if (fade_step) begin
          level_nxt = level - 1'b1;
          if (level == LEVEL_ONE) state_nxt = LOAD;
        end
      end
      LOAD: begin
        // Level is 0 here, so swapping the colour cannot glitch either LED.
        cur_color_nxt = pending;
        state_nxt     = FADE_IN;
      end
      FADE_IN: begin
        if (level == LEVEL_MAX) begin
          state_nxt = IDLE;
        end else if (fade_step) begin
          level_nxt = level + 1'b1;
          if (level == LEVEL_MAX - LEVEL_ONE) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered LED drive: colour and complement gated by the PWM compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_3bits_0 <= '0;
      rgb_3bits_1 <= '0;
    end else begin
      rgb_3bits_0 <= cur_color & {3{pwm_on}};
      rgb_3bits_1 <= ~cur_color & {3{pwm_on}};
    end
  end

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Bench for rgb_pwm_fader with PWM_BITS=4, PWM_DIV=1, FADE_TICKS=1.
// The reference model derives level, colour and ready for any cycle from the
// edge number of the last transfer (step edges are multiples of 16 after
// reset release); a scoreboard checks each fade's completion time and colour.
module tb_rgb_pwm_fader;

  localparam int PERIOD = 16;
  localparam int LMAX   = 15;
`ifdef RGB_PWM_GAMMA_EN
  localparam int EXP_ON8 = 6;
`else
  localparam int EXP_ON8 = 9;
`endif

  typedef struct {
    logic [2:0] col;
    int         e;
  } sb_item_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rgb0, rgb1;
  logic       busy;

  rgb_pwm_fader_if bus ();

  rgb_pwm_fader #(
    .PWM_BITS   (4),
    .PWM_DIV    (1),
    .FADE_TICKS (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .color_if    (bus),
    .rgb_3bits_0 (rgb0),
    .rgb_3bits_1 (rgb1),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur (t=%0t)", name, $time);
  endtask

  // Edge count since reset release: pwm_cnt after edge n is n mod 16.
  int edge_cnt;
  always @(posedge clk or posedge rst)
    if (rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;

  // Reference model state.
  bit         act;
  int         base_level;
  logic [2:0] base_col;
  int         f_k, f_l0, f_s, f_j, f_e;
  logic [2:0] f_old, f_new;
  int         xfer_cnt, xfer_k;
  logic [2:0] exp_rgb0, exp_rgb1;
  int         prev_lv;
  bit         prev_rise;
  bit         seen8;
  int         cnt8;
  sb_item_t   sb[$];

  function automatic int model_level(input int n);
    int lv;
    if (!act) return base_level;
    if (n < f_s) return f_l0 - (n / PERIOD - f_k / PERIOD);
    if (n < f_j) return 0;
    lv = n / PERIOD - f_j / PERIOD;
    return (lv > LMAX) ? LMAX : lv;
  endfunction

  function automatic logic [2:0] model_color(input int n);
    if (!act) return base_col;
    return (n < f_j) ? f_old : f_new;
  endfunction

  function automatic int model_duty(input int lv);
`ifdef RGB_PWM_GAMMA_EN
    return ((lv + 1) * (lv + 1) - 1) >> 4;
`else
    return lv;
`endif
  endfunction

  int         m_n, m_lv, m_du;
  logic [2:0] m_c;
  bit         m_on, m_rdy, m_rise;

  always @(negedge clk) begin
    if (rst) begin
      act = 0; base_level = 0; base_col = 3'b000;
      exp_rgb0 = 3'b000; exp_rgb1 = 3'b000;
      prev_lv = 0; prev_rise = 0; seen8 = 0; cnt8 = 0;
    end else begin
      m_n = edge_cnt;
      if (act && m_n >= f_e) begin
        base_level = LMAX; base_col = f_new; act = 0;
      end
      chk("rgb0_cycle", rgb0, exp_rgb0);
      chk("rgb1_cycle", rgb1, exp_rgb1);

      if (prev_rise && prev_lv == 8) begin
        seen8 = 1;
        if ((rgb0 | rgb1) != 3'b000) cnt8++;
      end else if (seen8) begin
        chk("duty_level8_on_cycles", cnt8, EXP_ON8);
        seen8 = 0; cnt8 = 0;
      end

      m_lv   = model_level(m_n);
      m_c    = model_color(m_n);
      m_du   = model_duty(m_lv);
      m_on   = (m_du != 0) && ((m_n % PERIOD) <= m_du);
      m_rdy  = !act;
      m_rise = act && (m_n >= f_j);
      exp_rgb0 = m_on ? m_c : 3'b000;
      exp_rgb1 = m_on ? ~m_c : 3'b000;
      prev_lv = m_lv;
      prev_rise = m_rise;
      chk("color_ready", bus.color_ready, m_rdy);
      chk("busy", busy, !m_rdy);

      if (bus.color_valid && m_rdy) begin
        f_k   = m_n + 1;
        f_l0  = m_lv;
        f_s   = (f_l0 == 0) ? f_k + 1 : (f_k / PERIOD + f_l0) * PERIOD;
        f_j   = f_s + 1;
        f_e   = (f_j / PERIOD + LMAX) * PERIOD;
        f_old = m_c;
        f_new = bus.color;
        act   = 1;
        xfer_k = f_k;
        xfer_cnt++;
        sb.push_back('{col: bus.color, e: f_e});
      end
    end
  end

  // Scoreboard monitor: a fade completes when color_ready rises.
  bit         prev_ready;
  bit         final_chk;
  logic [2:0] fin_col, fin_inv;
  sb_item_t   item;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      final_chk = 0;
    end else begin
      if (final_chk) begin
        chk("final_rgb0", rgb0, fin_col);
        chk("final_rgb1", rgb1, fin_inv);
        final_chk = 0;
      end
      if (!prev_ready && bus.color_ready) begin
        if (sb.size() == 0) begin
          fail_now("sb_unexpected_done");
        end else begin
          item = sb.pop_front();
          chk("done_edge", edge_cnt, item.e);
          fin_col = item.col;
          fin_inv = ~item.col;
          final_chk = 1;
        end
      end
    end
    prev_ready = bus.color_ready;
  end

  task automatic send(input logic [2:0] col);
    bit done = 0;
    @(posedge clk); #1;
    bus.color_valid = 1'b1;
    bus.color = col;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (bus.color_ready) done = 1;
    end
    if (!done) fail_now("send_timeout");
    @(posedge clk); #1;
    bus.color_valid = 1'b0;
  endtask

  task automatic wait_ready();
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (bus.color_ready) done = 1;
    end
    if (!done) fail_now("ready_timeout");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int  e_prev, cnt0;
  bit  found;

  initial begin
    bus.color_valid = 1'b0;
    bus.color = 3'b000;

    // Reset held: outputs quiet, block ready.
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("rst_rgb0", rgb0, 3'b000);
      chk("rst_rgb1", rgb1, 3'b000);
      chk("rst_ready", bus.color_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // First fade from reset to 101, then 101 -> 011.
    send(3'b101);
    wait_ready();
    repeat (20) @(negedge clk);
    chk("steady_rgb0", rgb0, 3'b101);
    chk("steady_rgb1", rgb1, 3'b010);

    // 110 is offered every cycle of the 101 -> 011 fade.
    send(3'b011);
    e_prev = f_e;
    bus.color_valid = 1'b1;
    bus.color = 3'b110;
    cnt0 = xfer_cnt;
    found = 0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk); #1;
      if (xfer_cnt != cnt0) found = 1;
    end
    if (!found) fail_now("held_code_timeout");
    @(posedge clk); #1;
    bus.color_valid = 1'b0;
    chk("accept_first_idle", xfer_k, e_prev + 1);
    wait_ready();

    // Asynchronous reset at level 7 of a fade-in, while the LEDs are lit.
    send(3'b010);
    found = 0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk); #1;
      if (act && edge_cnt >= f_j && model_level(edge_cnt) == 7 &&
          (edge_cnt % PERIOD == 2 || edge_cnt % PERIOD == 3)) found = 1;
    end
    if (!found) fail_now("level7_timeout");
    chk("pre_reset_lit", ((rgb0 | rgb1) != 3'b000), 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_rgb0", rgb0, 3'b000);
    chk("async_rst_rgb1", rgb1, 3'b000);
    chk("async_rst_ready", bus.color_ready, 1'b1);
    chk("async_rst_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    send(3'b001);
    wait_ready();

    // Random colours with random (ignored unless ready) traffic during fades.
    for (int t = 0; t < 6; t++) begin
      repeat ($urandom_range(0, 40)) @(posedge clk);
      send(3'($urandom));
      found = 0;
      for (int i = 0; i < 3000 && !found; i++) begin
        @(negedge clk);
        if (bus.color_ready) begin
          found = 1;
        end else begin
          @(posedge clk); #1;
          bus.color_valid = 1'($urandom_range(0, 1));
          bus.color = 3'($urandom);
        end
      end
      if (!found) fail_now("random_fade_timeout");
      @(posedge clk); #1;
      bus.color_valid = 1'b0;
      wait_ready();
    end

    repeat (5) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
